// File: rtl/rgu_pkg.sv
// Shared types and constants for the SCU reset generation unit.
package rgu_pkg;

   // Number of entries in the main reset table; one soft-reset slot per entry.
   localparam int unsigned RGU_NUM_MOD_MAIN = 13;

   // Default field widths for the per-module soft-reset scheduler.
   localparam int unsigned RGU_PULSE_W = 8;
   localparam int unsigned RGU_TO_W    = 16;

   // Per-module soft-reset scheduler states.
   typedef enum logic [1:0] {
      StIdle,
      StQuiesce,
      StAssert,
      StRelease
   } rgu_mrc_state_e;

endpackage

// File: rtl/rgu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rgu_rr_pick #(
   parameter int unsigned NUM_MOD = 13
) (
   input  logic [NUM_MOD-1:0]         req,
   input  logic [$clog2(NUM_MOD)-1:0] ptr,
   output logic                       valid,
   output logic [$clog2(NUM_MOD)-1:0] idx
);

   localparam int unsigned IDX_W = $clog2(NUM_MOD);

   // Two copies back to back turn the wrap-around search into one linear scan
   // starting at ptr; the first hit is always within ptr .. ptr+NUM_MOD-1.
   logic [2*NUM_MOD-1:0] req_dbl;

   assign req_dbl = {req, req};

   // Find-first over the doubled vector, ignoring positions below ptr.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int unsigned j = 0; j < 2 * NUM_MOD; j++) begin
         if (!valid && req_dbl[j] && (j >= 32'(ptr))) begin
            valid = 1'b1;
            idx   = (j >= NUM_MOD) ? IDX_W'(j - NUM_MOD) : IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/rgu_mod_rst_ctrl.sv
// Per-module soft-reset scheduler: collects module reset requests, services them
// round-robin, quiescing each target before driving a timed reset pulse.
module rgu_mod_rst_ctrl
   import rgu_pkg::*;
#(
   parameter int unsigned NUM_MOD = RGU_NUM_MOD_MAIN,
   parameter int unsigned PULSE_W = RGU_PULSE_W,
   parameter int unsigned TO_W    = RGU_TO_W
) (
   input  logic                       sys_clk_i,
   input  logic                       rst_n_i,
   input  logic                       abort_i,
   input  logic [NUM_MOD-1:0]         req_i,
   input  logic [NUM_MOD-1:0]         mask_i,
   input  logic [PULSE_W-1:0]         pulse_len_i,
   input  logic [TO_W-1:0]            timeout_i,
   output logic [NUM_MOD-1:0]         quiesce_req_o,
   input  logic [NUM_MOD-1:0]         quiesce_ack_i,
   output logic [NUM_MOD-1:0]         mod_rst_req_o,
   output logic [NUM_MOD-1:0]         pending_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [$clog2(NUM_MOD)-1:0] done_idx_o,
   output logic                       to_err_o,
   input  logic                       to_err_clr_i
);

   localparam int unsigned IDX_W = $clog2(NUM_MOD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOD - 1);

   rgu_mrc_state_e      state;
   logic [NUM_MOD-1:0]  pending;
   logic [IDX_W-1:0]    ptr;
   logic [IDX_W-1:0]    sel;
   logic [PULSE_W-1:0]  pulse_cnt;
   logic [TO_W-1:0]     wait_cnt;

   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;
   logic [NUM_MOD-1:0]  pick_oh;
   logic [NUM_MOD-1:0]  sel_oh;
   logic [NUM_MOD-1:0]  grant_oh;
   logic [PULSE_W-1:0]  pulse_load;
   logic                grant;
   logic                ack_sel;
   logic                to_hit;

   function automatic logic [NUM_MOD-1:0] to_onehot(input logic [IDX_W-1:0] i);
      return {{(NUM_MOD - 1){1'b0}}, 1'b1} << i;
   endfunction

   rgu_rr_pick #(
      .NUM_MOD (NUM_MOD)
   ) u_pick (
      .req   (pending),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign pick_oh = to_onehot(pick_idx);
   assign sel_oh  = to_onehot(sel);
   assign ack_sel = |(quiesce_ack_i & sel_oh);

   // RELEASE doubles as an idle cycle so the next grant can follow it directly;
   // ptr has already moved past the finished module by then.
   assign grant    = !abort_i && pick_valid && ((state == StIdle) || (state == StRelease));
   assign grant_oh = grant ? pick_oh : '0;

   // A zero pulse length still yields a single reset cycle.
   assign pulse_load = (pulse_len_i == '0) ? PULSE_W'(1) : pulse_len_i;

   // Ack takes priority over a timeout landing in the same cycle.
   assign to_hit = !abort_i && (state == StQuiesce) && !ack_sel &&
                   (timeout_i != '0) && (wait_cnt == timeout_i);

   assign busy_o    = (state != StIdle);
   assign pending_o = pending;

   // Pending set: grant clears the chosen bit, new requests merge in, mask wins.
   always_ff @(posedge sys_clk_i) begin
      if (!rst_n_i || abort_i) begin
         pending <= '0;
      end else begin
         pending <= ((pending & ~grant_oh) | req_i) & ~mask_i;
      end
   end

   // Scheduler FSM with registered one-hot outputs, pointer and counters.
   always_ff @(posedge sys_clk_i) begin
      if (!rst_n_i) begin
         state         <= StIdle;
         sel           <= '0;
         ptr           <= '0;
         pulse_cnt     <= '0;
         wait_cnt      <= '0;
         quiesce_req_o <= '0;
         mod_rst_req_o <= '0;
         done_o        <= 1'b0;
         done_idx_o    <= '0;
      end else if (abort_i) begin
         // Flush without completion; ptr keeps its position.
         state         <= StIdle;
         pulse_cnt     <= '0;
         wait_cnt      <= '0;
         quiesce_req_o <= '0;
         mod_rst_req_o <= '0;
         done_o        <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            StIdle, StRelease: begin
               quiesce_req_o <= '0;
               mod_rst_req_o <= '0;
               if (pick_valid) begin
                  sel           <= pick_idx;
                  quiesce_req_o <= pick_oh;
                  wait_cnt      <= '0;
                  state         <= StQuiesce;
               end else begin
                  state <= StIdle;
               end
            end
            StQuiesce: begin
               if (ack_sel || to_hit) begin
                  // Timeout forces the reset anyway; quiesce_req stays asserted.
                  pulse_cnt     <= pulse_load;
                  mod_rst_req_o <= sel_oh;
                  state         <= StAssert;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            StAssert: begin
               if (pulse_cnt <= PULSE_W'(1)) begin
                  quiesce_req_o <= '0;
                  mod_rst_req_o <= '0;
                  done_o        <= 1'b1;
                  done_idx_o    <= sel;
                  ptr           <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                  state         <= StRelease;
               end else begin
                  pulse_cnt <= pulse_cnt - 1'b1;
               end
            end
            default: begin
               quiesce_req_o <= '0;
               mod_rst_req_o <= '0;
               state         <= StIdle;
            end
         endcase
      end
   end

   // Sticky timeout flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge sys_clk_i) begin
      if (!rst_n_i) begin
         to_err_o <= 1'b0;
      end else if (to_hit) begin
         to_err_o <= 1'b1;
      end else if (to_err_clr_i) begin
         to_err_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rgu_mod_rst_ctrl.sv
// Self-checking bench for rgu_mod_rst_ctrl: directed scenarios plus a randomized
// run against a timestamp-based reference model.
module tb_rgu_mod_rst_ctrl;

   localparam int N  = 13;
   localparam int IW = $clog2(N);
   localparam logic [N-1:0] ONE = 1;

   logic          clk = 1'b0;
   logic          rst_n, abort, to_err_clr;
   logic [N-1:0]  req, mask, q_ack;
   logic [7:0]    pulse_len;
   logic [15:0]   timeout;
   logic [N-1:0]  q_req, rst_req, pending;
   logic          busy, done, to_err;
   logic [IW-1:0] done_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rgu_mod_rst_ctrl #(
      .NUM_MOD (N),
      .PULSE_W (8),
      .TO_W    (16)
   ) dut (
      .sys_clk_i     (clk),
      .rst_n_i       (rst_n),
      .abort_i       (abort),
      .req_i         (req),
      .mask_i        (mask),
      .pulse_len_i   (pulse_len),
      .timeout_i     (timeout),
      .quiesce_req_o (q_req),
      .quiesce_ack_i (q_ack),
      .mod_rst_req_o (rst_req),
      .pending_o     (pending),
      .busy_o        (busy),
      .done_o        (done),
      .done_idx_o    (done_idx),
      .to_err_o      (to_err),
      .to_err_clr_i  (to_err_clr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; abort = 1'b0; req = '0; mask = '0; q_ack = '1;
      pulse_len = 8'd1; timeout = '0; to_err_clr = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; abort = 1'b0; req = '1; mask = '0; q_ack = '1;
      pulse_len = 8'd4; timeout = '0; to_err_clr = 1'b0;
      step(); step();
      checks++; if (q_req !== '0) begin errors++; $display("FAIL reset_q_req: got %h expected 0", q_req); end
      checks++; if (rst_req !== '0) begin errors++; $display("FAIL reset_rst_req: got %h expected 0", rst_req); end
      checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (done_idx !== '0) begin errors++; $display("FAIL reset_done_idx: got %0d expected 0", done_idx); end
      checks++; if (to_err !== 1'b0) begin errors++; $display("FAIL reset_to_err: got %b expected 0", to_err); end
      req = '0; rst_n = 1'b1;
      step();
      checks++; if (pending !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_no_capture: got pending %h busy %b expected 0 0", pending, busy); end
   endtask

   task automatic test_single();
      do_reset();
      pulse_len = 8'd4;
      req = ONE << 5; step(); req = '0;            // T+1
      checks++; if (pending !== (ONE << 5)) begin errors++; $display("FAIL single_pending: got %h expected %h", pending, ONE << 5); end
      checks++; if (q_req !== '0) begin errors++; $display("FAIL single_q_early: got %h expected 0", q_req); end
      step();                                      // T+2
      checks++; if (q_req !== (ONE << 5)) begin errors++; $display("FAIL single_q_req: got %h expected %h", q_req, ONE << 5); end
      checks++; if (rst_req !== '0 || pending !== '0 || busy !== 1'b1) begin errors++; $display("FAIL single_grant: got rst %h pend %h busy %b expected 0 0 1", rst_req, pending, busy); end
      for (int c = 3; c <= 6; c++) begin
         step();
         checks++; if (rst_req !== (ONE << 5) || q_req !== (ONE << 5) || done !== 1'b0) begin errors++; $display("FAIL single_assert_T%0d: got rst %h q %h done %b expected %h %h 0", c, rst_req, q_req, done, ONE << 5, ONE << 5); end
      end
      step();                                      // T+7
      checks++; if (done !== 1'b1 || done_idx !== IW'(5)) begin errors++; $display("FAIL single_done: got done %b idx %0d expected 1 5", done, done_idx); end
      checks++; if (rst_req !== '0 || q_req !== '0) begin errors++; $display("FAIL single_release: got rst %h q %h expected 0 0", rst_req, q_req); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got done %b busy %b expected 0 0", done, busy); end
   endtask

   task automatic test_round_robin();
      int order[$];
      int bad;
      bit seen;
      do_reset();
      pulse_len = 8'd1;
      // Service module 7 alone so the pointer lands on 8.
      req = ONE << 7; step(); req = '0;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         step();
         if (done) seen = 1'b1;
      end
      checks++; if (!seen || done_idx !== IW'(7)) begin errors++; $display("FAIL rr_prep: got seen %b idx %0d expected 1 7", seen, done_idx); end
      step();
      req = (ONE << 2) | (ONE << 7) | (ONE << 11); step(); req = '0;
      bad = 0;
      for (int c = 0; c < 80 && order.size() < 3; c++) begin
         if ($countones(q_req) > 1 || $countones(rst_req) > 1) bad++;
         if (q_req !== '0 && rst_req !== '0 && q_req !== rst_req) bad++;
         if (done) order.push_back(int'(done_idx));
         step();
      end
      checks++; if (order.size() != 3) begin errors++; $display("FAIL rr_count: got %0d expected 3", order.size()); end
      checks++; if (order.size() < 1 || order[0] != 11) begin errors++; $display("FAIL rr_first: got %0d expected 11", (order.size() > 0) ? order[0] : -1); end
      checks++; if (order.size() < 2 || order[1] != 2) begin errors++; $display("FAIL rr_second: got %0d expected 2", (order.size() > 1) ? order[1] : -1); end
      checks++; if (order.size() < 3 || order[2] != 7) begin errors++; $display("FAIL rr_third: got %0d expected 7", (order.size() > 2) ? order[2] : -1); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rr_onehot: got %0d violations expected 0", bad); end
   endtask

   task automatic test_timeout();
      int early;
      do_reset();
      timeout = 16'd10; pulse_len = 8'd2; q_ack = ~(ONE << 3);
      req = ONE << 3; step(); req = '0; step();    // grant cycle G
      checks++; if (q_req !== (ONE << 3)) begin errors++; $display("FAIL tmo_grant: got %h expected %h", q_req, ONE << 3); end
      early = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (rst_req !== '0) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL tmo_early: got %0d early cycles expected 0", early); end
      checks++; if (to_err !== 1'b0) begin errors++; $display("FAIL tmo_err_pre: got %b expected 0", to_err); end
      to_err_clr = 1'b1; step(); to_err_clr = 1'b0;   // G+11, clear collides with set
      checks++; if (rst_req !== (ONE << 3)) begin errors++; $display("FAIL tmo_forced: got %h expected %h", rst_req, ONE << 3); end
      checks++; if (to_err !== 1'b1) begin errors++; $display("FAIL tmo_set_wins: got %b expected 1", to_err); end
      step(); step();
      checks++; if (done !== 1'b1 || done_idx !== IW'(3)) begin errors++; $display("FAIL tmo_done: got done %b idx %0d expected 1 3", done, done_idx); end
      checks++; if (to_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", to_err); end
      to_err_clr = 1'b1; step(); to_err_clr = 1'b0;
      checks++; if (to_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", to_err); end
   endtask

   task automatic test_mask_zero_len();
      int bad;
      do_reset();
      pulse_len = 8'd0; q_ack = '0;
      mask = ONE << 4; req = ONE << 4; step(); req = '0;
      checks++; if (pending !== '0) begin errors++; $display("FAIL mask_capture: got %h expected 0", pending); end
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (busy || q_req !== '0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mask_grant: got %0d grant cycles expected 0", bad); end
      mask = '0;
      req = ONE << 6; step(); req = '0; step();
      checks++; if (q_req !== (ONE << 6)) begin errors++; $display("FAIL mask_hold6: got %h expected %h", q_req, ONE << 6); end
      req = ONE << 4; step(); req = '0;
      checks++; if (pending !== (ONE << 4)) begin errors++; $display("FAIL mask_pend4: got %h expected %h", pending, ONE << 4); end
      mask = ONE << 4; step();
      checks++; if (pending !== '0) begin errors++; $display("FAIL mask_clear: got %h expected 0", pending); end
      mask = '0; q_ack = '1; step();
      checks++; if (rst_req !== (ONE << 6)) begin errors++; $display("FAIL zlen_assert: got %h expected %h", rst_req, ONE << 6); end
      step();
      checks++; if (rst_req !== '0 || done !== 1'b1 || done_idx !== IW'(6)) begin errors++; $display("FAIL zlen_one_cycle: got rst %h done %b idx %0d expected 0 1 6", rst_req, done, done_idx); end
   endtask

   task automatic test_abort();
      int bad;
      do_reset();
      pulse_len = 8'd20;
      req = ONE << 1; step(); req = '0; step(); step();
      checks++; if (rst_req !== (ONE << 1)) begin errors++; $display("FAIL abort_pre: got %h expected %h", rst_req, ONE << 1); end
      req = (ONE << 0) | (ONE << 5) | (ONE << 8); step(); req = '0; step();
      checks++; if (pending !== ((ONE << 0) | (ONE << 5) | (ONE << 8))) begin errors++; $display("FAIL abort_pend: got %h expected %h", pending, (ONE << 0) | (ONE << 5) | (ONE << 8)); end
      abort = 1'b1; req = ONE << 10; step(); abort = 1'b0; req = '0;
      checks++; if (q_req !== '0 || rst_req !== '0) begin errors++; $display("FAIL abort_outs: got q %h rst %h expected 0 0", q_req, rst_req); end
      checks++; if (pending !== '0) begin errors++; $display("FAIL abort_flush: got %h expected 0", pending); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b done %b expected 0 0", busy, done); end
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (done || busy || pending !== '0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
   endtask

   task automatic test_rerequest();
      int dones, bad;
      do_reset();
      pulse_len = 8'd3;
      req = ONE << 9; step(); req = '0; step(); step();
      checks++; if (rst_req !== (ONE << 9)) begin errors++; $display("FAIL rereq_assert: got %h expected %h", rst_req, ONE << 9); end
      req = ONE << 9; step(); req = '0;
      checks++; if (pending !== (ONE << 9)) begin errors++; $display("FAIL rereq_pend: got %h expected %h", pending, ONE << 9); end
      dones = 0; bad = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) begin
            dones++;
            if (done_idx !== IW'(9)) bad++;
         end
         step();
      end
      checks++; if (dones != 2 || bad != 0) begin errors++; $display("FAIL rereq_twice: got %0d completions (%0d wrong idx) expected 2", dones, bad); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      q_ack = '0;
      req = ONE << 2; step(); req = '0; step(); step(); step();
      checks++; if (q_req !== (ONE << 2) || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got q %h busy %b expected %h 1", q_req, busy, ONE << 2); end
      rst_n = 1'b0; step();
      checks++; if (q_req !== '0 || rst_req !== '0 || pending !== '0 || busy || done || to_err) begin errors++; $display("FAIL rstmid_zero: got q %h rst %h pend %h busy %b done %b err %b expected all 0", q_req, rst_req, pending, busy, done, to_err); end
      rst_n = 1'b1;
   endtask

   // Reference model: the module in service is tracked by timestamps
   // (grant cycle, reset start cycle, reset length) rather than a state machine.
   task automatic test_random();
      int now, svc, grant_c, rs, len, ptr;
      logic [N-1:0] pend, exp_q, exp_r, gbit;
      logic err, exp_done, hit, found;
      int idx;
      do_reset();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      svc = -1; grant_c = 0; rs = -1; len = 0; ptr = 0; pend = '0; err = 1'b0;
      for (now = 0; now < 3000; now++) begin
         exp_q = '0; exp_r = '0; exp_done = 1'b0;
         if (svc >= 0) begin
            if (!(rs >= 0 && now >= rs + len)) exp_q[svc] = 1'b1;
            if (rs >= 0 && now >= rs && now < rs + len) exp_r[svc] = 1'b1;
            exp_done = (rs >= 0 && now == rs + len);
         end
         checks++; if (q_req !== exp_q) begin errors++; $display("FAIL rnd_q_req@%0d: got %h expected %h", now, q_req, exp_q); end
         checks++; if (rst_req !== exp_r) begin errors++; $display("FAIL rnd_rst_req@%0d: got %h expected %h", now, rst_req, exp_r); end
         checks++; if (pending !== pend) begin errors++; $display("FAIL rnd_pending@%0d: got %h expected %h", now, pending, pend); end
         checks++; if (busy !== (svc >= 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", now, busy, svc >= 0); end
         checks++; if (done !== exp_done) begin errors++; $display("FAIL rnd_done@%0d: got %b expected %b", now, done, exp_done); end
         if (exp_done) begin
            checks++; if (int'(done_idx) != svc) begin errors++; $display("FAIL rnd_done_idx@%0d: got %0d expected %0d", now, done_idx, svc); end
         end
         checks++; if (to_err !== err) begin errors++; $display("FAIL rnd_to_err@%0d: got %b expected %b", now, to_err, err); end

         // Stimulus for this cycle.
         req = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom & $urandom) : '0;
         if ($urandom_range(0, 49) == 0) mask = N'($urandom & $urandom & $urandom);
         q_ack = N'($urandom & $urandom & $urandom);
         pulse_len = 8'($urandom_range(0, 4));
         if (now % 500 == 0) timeout = 16'($urandom_range(0, 2) * 3);
         abort = ($urandom_range(0, 199) == 0);
         to_err_clr = ($urandom_range(0, 39) == 0);

         // Model update for the end of this cycle.
         hit = 1'b0;
         if (svc >= 0 && rs < 0) begin
            if (q_ack[svc]) begin
               rs = now + 1; len = (pulse_len == 0) ? 1 : int'(pulse_len);
            end else if (timeout != 0 && (now - grant_c) == int'(timeout)) begin
               hit = 1'b1; rs = now + 1; len = (pulse_len == 0) ? 1 : int'(pulse_len);
            end
         end
         if (svc >= 0 && rs >= 0 && now == rs + len) ptr = (svc + 1) % N;
         if (!abort && hit) err = 1'b1;
         else if (to_err_clr) err = 1'b0;
         if (abort) begin
            svc = -1; pend = '0;
         end else begin
            gbit = '0;
            if (svc < 0 || (rs >= 0 && now == rs + len)) begin
               svc = -1; found = 1'b0;
               for (int k = 0; k < N; k++) begin
                  idx = (ptr + k) % N;
                  if (!found && pend[idx]) begin
                     found = 1'b1; svc = idx; grant_c = now + 1; rs = -1; gbit[idx] = 1'b1;
                  end
               end
            end
            pend = ((pend & ~gbit) | req) & ~mask;
         end
         step();
      end
      abort = 1'b0; req = '0; mask = '0; to_err_clr = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_mask_zero_len();
      test_abort();
      test_rerequest();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgu_mod_rst_ctrl.md
# rgu_mod_rst_ctrl

Per-module soft-reset scheduler in the SCU reset generation unit. It collects single-module reset requests from SCU registers and services them one at a time in round-robin order. For each module it first quiesces the target through a request/ack handshake, then drives that module's reset request for a programmable number of cycles. Its `mod_rst_req_o` vector feeds the per-module `mod_rst_req_i` inputs of the reset generator.

## Interface
Parameters:
- `NUM_MOD`, 13: number of resettable modules (matches the main reset table size).
- `PULSE_W`, 8: width of the reset pulse-length field.
- `TO_W`, 16: width of the quiesce timeout field.

Ports:
- `sys_clk_i`  in  1  system clock; the only clock.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `abort_i`  in  1  global sw/wdt reset in progress; flushes the scheduler.
- `req_i`  in  NUM_MOD  one-cycle request pulse per module.
- `mask_i`  in  NUM_MOD  1 = module excluded from soft reset.
- `pulse_len_i`  in  PULSE_W  reset assertion length in cycles; 0 is treated as 1.
- `timeout_i`  in  TO_W  quiesce timeout in cycles; 0 = wait forever.
- `quiesce_req_o`  out  NUM_MOD  ask module to idle; one-hot or zero.
- `quiesce_ack_i`  in  NUM_MOD  module idle acknowledge, level.
- `mod_rst_req_o`  out  NUM_MOD  active-high reset request; one-hot or zero.
- `pending_o`  out  NUM_MOD  requests accepted but not yet granted.
- `busy_o`  out  1  FSM not in IDLE.
- `done_o`  out  1  one-cycle pulse when a module's reset completes.
- `done_idx_o`  out  $clog2(NUM_MOD)  index of the completed module, valid with `done_o`.
- `to_err_o`  out  1  sticky flag: a quiesce timeout occurred.
- `to_err_clr_i`  in  1  clears `to_err_o`.

## Operation
- **Capture:**
  - `pending[i]` is set on `req_i[i] & ~mask_i[i]`.
  - A repeated request while pending merges into the existing one.
  - `mask_i[i]=1` clears `pending[i]` and blocks new captures for that module.
  - A request for the module currently in service sets `pending` again, so it is serviced again later.
- **Arbitration:** round-robin. `sel` is the first pending index at or after `ptr`, wrapping modulo `NUM_MOD`. After each completion, `ptr` is set to `sel+1` (wrapping to 0 at the top).
- **FSM states:** IDLE, QUIESCE, ASSERT, RELEASE.
  - **IDLE:**
    - If `pending` is nonzero, latch `sel`, clear `pending[sel]`, drive `quiesce_req_o[sel]=1`, and go to QUIESCE.
  - **QUIESCE:**
    - When `quiesce_ack_i[sel]=1`, load the pulse counter with `max(pulse_len_i,1)` and go to ASSERT.
    - If `timeout_i!=0` and the wait counter reaches `timeout_i`, set `to_err_o` and go to ASSERT anyway (forced reset).
  - **ASSERT:**
    - `mod_rst_req_o[sel]=1` and `quiesce_req_o[sel]` is held high.
    - The counter decrements each cycle; leave the state when it reaches 1.
  - **RELEASE:**
    - All outputs are deasserted for one settle cycle.
    - `done_o=1` with `done_idx_o=sel`, `ptr` is advanced, and the FSM returns to IDLE.
- **Abort:**
  - `abort_i` has the highest priority. From any state, the next state is IDLE, `pending` is cleared, `quiesce_req_o` and `mod_rst_req_o` go to 0, and no `done_o` is issued.
  - `req_i` in the same cycle as `abort_i` is dropped. `ptr` is preserved.
- **Error flag:** `to_err_clr_i` and a new timeout in the same cycle leave `to_err_o=1` (set wins).

## Timing
- **Reset values:** every output 0; state IDLE; `pending`, `ptr`, counters 0; `to_err_o` 0.
- **Request latency:** `req_i` at cycle T gives `pending_o` at T+1 and `quiesce_req_o` at T+2, if the FSM is idle.
- **Ack latency:** `quiesce_ack_i` at cycle A gives `mod_rst_req_o` high from A+1 for exactly N=`max(pulse_len_i,1)` cycles.
- **Completion:** RELEASE, and with it `done_o`, occurs at A+1+N. The next grant can appear at A+2+N.
- **Inter-grant spacing:** minimum 1 cycle with both output vectors zero; the two one-hot outputs never switch module in the same cycle.
- **Sampling:**
  - `pulse_len_i` is sampled only on the QUIESCE→ASSERT transition.
  - `timeout_i` is compared each QUIESCE cycle. The wait counter starts at 0 on entry and saturates.
- **Forced reset:** on timeout, ASSERT begins the cycle after the counter equals `timeout_i`.

## Structure
- **Shared package** `rgu_pkg`:
  - `rgu_mrc_state_e` enum (IDLE, QUIESCE, ASSERT, RELEASE).
  - Localparam `RGU_NUM_MOD_MAIN=13`.
- **Sub-module** `rgu_rr_pick`: combinational round-robin picker. Inputs `req[NUM_MOD]` and `ptr`; outputs `valid` and `idx`. Implemented as a double-width find-first.
- **Top:** `rgu_mod_rst_ctrl` holds the FSM, the pending register, the counters and the error flag.

## Test plan
- **Single module:** `NUM_MOD=13`, `pulse_len_i=4`, ack tied high. Pulse `req_i[5]` at T → `quiesce_req_o[5]` at T+2, `mod_rst_req_o[5]` high for T+3..T+6, `done_o` with `done_idx_o=5` at T+7.
- **Round robin:** `req_i[2]`, `req_i[7]` and `req_i[11]` in the same cycle with `ptr=8` → service order 11, 2, 7; never more than one output bit set.
- **Timeout:** `timeout_i=10`, ack held low on module 3 → `mod_rst_req_o[3]` asserts 11 cycles after the grant and `to_err_o=1`. Then `to_err_clr_i` → 0.
- **Mask and zero length:** `req_i[4]` with `mask_i[4]=1` → never granted. Set the mask while 4 is pending → `pending_o[4]` clears. `pulse_len_i=0` → exactly a 1-cycle `mod_rst_req_o`.
- **Abort:** assert `abort_i` mid-ASSERT with 3 requests pending → next cycle everything is 0 and the FSM is idle, with no `done_o`.
- **Re-request and reset:** re-request the in-service module → serviced twice. Drive `rst_n_i` low mid-QUIESCE → all outputs 0 on the following edge.
